// File: rtl/trigger_event_buffer.sv
// Timestamps and sequences engine triggers, applies per-channel holdoff, queues events in a FWFT FIFO.
// Events appear one cycle after sampling; full FIFO drops (counted) unless a pop frees a slot that cycle.
module trigger_event_buffer #(
   parameter int NUM_CHANNELS  = 16,
   parameter int CHANNEL_WIDTH = $clog2(NUM_CHANNELS),
   parameter int FIFO_DEPTH    = 16,
   parameter int TS_WIDTH      = 32,
   parameter int HOLDOFF_WIDTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          trig_valid_i,
   input  logic [7:0]                    trig_confidence_i,
   input  logic [15:0]                   trig_metadata_i,
   input  logic                          capture_en_i,
   input  logic                          clear_i,
   input  logic [HOLDOFF_WIDTH-1:0]      holdoff_cycles_i,
   output logic [63:0]                   evt_data_o,
   output logic                          evt_valid_o,
   input  logic                          evt_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic [15:0]                   drop_count_o,
   output logic [15:0]                   suppress_count_o
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CMP_W = (TS_WIDTH > HOLDOFF_WIDTH) ? TS_WIDTH : HOLDOFF_WIDTH;

   logic [TS_WIDTH-1:0]      ts_q, ts_d;
   logic [7:0]               seq_q, seq_d;
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]         count_q, count_d;
   logic [15:0]              drop_q, drop_d, supp_q, supp_d;
   logic [NUM_CHANNELS-1:0]  armed_q, armed_d;
   logic [63:0]              mem_q [FIFO_DEPTH];
   logic [TS_WIDTH-1:0]      last_ts_q [NUM_CHANNELS];

   logic [3:0]               ch_raw;
   logic [CHANNEL_WIDTH-1:0] ch_idx;
   logic                     ch_ok, cand, suppress, track, push, pop, has_room, drop;
   logic [TS_WIDTH-1:0]      delta;
   logic [63:0]              entry;

   always_comb begin
      ch_raw   = trig_metadata_i[11:8];
      ch_idx   = CHANNEL_WIDTH'(ch_raw);
      ch_ok    = 32'(ch_raw) < NUM_CHANNELS;
      cand     = trig_valid_i && capture_en_i && ch_ok;
      // modular distance keeps the holdoff window correct across timestamp wrap
      delta    = ts_q - last_ts_q[ch_idx];
      suppress = cand && armed_q[ch_idx] && (holdoff_cycles_i != '0)
                 && (CMP_W'(delta) < CMP_W'(holdoff_cycles_i));
      pop      = (count_q != '0) && evt_ready_i;
      has_room = (count_q < LVL_W'(FIFO_DEPTH)) || pop;
      track    = cand && !suppress;
      push     = track && has_room;
      drop     = track && !has_room;
      entry    = {32'(ts_q), seq_q, trig_confidence_i, trig_metadata_i};
   end

   always_comb begin
      ts_d     = ts_q + TS_WIDTH'(1);
      seq_d    = seq_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      supp_d   = supp_q;
      armed_d  = armed_q;
      if (push) begin
         seq_d    = seq_q + 8'd1;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + LVL_W'(1);
         2'b01:   count_d = count_q - LVL_W'(1);
         default: count_d = count_q;
      endcase
      if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      if (suppress && supp_q != 16'hFFFF) supp_d = supp_q + 16'd1;
      if (track) armed_d[ch_idx] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         ts_q     <= '0;
         seq_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
         supp_q   <= '0;
         armed_q  <= '0;
      end else begin
         ts_q     <= ts_d;
         seq_q    <= seq_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         supp_q   <= supp_d;
         armed_q  <= armed_d;
      end
   end

   // storage needs no reset: pointers, count and armed flags qualify every read
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= entry;
      if (track) last_ts_q[ch_idx] <= ts_q;
   end

   assign evt_valid_o      = (count_q != '0);
   assign evt_data_o       = evt_valid_o ? mem_q[rd_ptr_q] : 64'd0;
   assign fifo_level_o     = count_q;
   assign drop_count_o     = drop_q;
   assign suppress_count_o = supp_q;
endmodule
